bcd_down_counter: RTL and testbench

Multi-digit BCD down-counter: the count-down counterpart to the decade up-counter used for pixel/line and on-screen digit counting. It loads a BCD value, decrements by one per enabled cycle with a borrow chain across digits, and signals terminal count. In stop mode it halts at zero; in reload mode it restarts from the loaded value. It drives countdown timers and on-screen decrementing digit displays in the VGA pipeline.

---
 rtl/bcd_down_counter_pkg.sv | 13 +
 rtl/bcd_digit_down.sv | 29 ++
 rtl/bcd_down_counter.sv | 80 ++++++++
 tb/tb_bcd_down_counter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bcd_down_counter_pkg.sv
// bcd_down_counter_pkg: shared state encodings, BCD constants and digit saturation helper
package bcd_down_counter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;
  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one BCD digit with clear, saturating load and borrow-driven down-step
module bcd_digit_down
  import bcd_down_counter_pkg::*;
(
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_step,
  output logic [3:0] o_digit,
  output logic       o_is_zero
);
  logic [3:0] digit_q, digit_d;
  // next digit: clear beats load beats step; stepping from 0 wraps to 9
  always_comb begin
    digit_d = i_clr  ? BCD_ZERO :
              i_load ? sat_digit(i_load_val) :
              i_step ? ((digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1) :
                       digit_q;
  end
  // digit register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) digit_q <= BCD_ZERO;
    else          digit_q <= digit_d;
  end
  assign o_digit   = digit_q;
  assign o_is_zero = (digit_q == BCD_ZERO);
endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: multi-digit BCD down-counter with stop/auto-reload terminal handling
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int W      = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_sclr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_reload,
  output logic [W-1:0] o_cnt,
  output logic         o_zero,
  output logic         o_tc,
  output logic         o_done
);
  state_e         state_q, state_d;
  logic [W-1:0]   reload_q, reload_d;
  logic [W-1:0]   sat_val;
  logic           tc_q, tc_d;
  logic [DIGITS-1:0] dig_zero;
  logic [DIGITS:0]   zero_chain;
  logic           run_en, dec, term, dig_load;
  logic [W-1:0]   dig_val;

  assign zero_chain[0] = 1'b1;

  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_dig
      assign zero_chain[k+1]  = zero_chain[k] & dig_zero[k];
      assign sat_val[4*k +: 4] = sat_digit(i_load_val[4*k +: 4]);
      bcd_digit_down u_dig (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (i_sclr),
        .i_load     (dig_load),
        .i_load_val (dig_val[4*k +: 4]),
        .i_step     (dec & zero_chain[k]),
        .o_digit    (o_cnt[4*k +: 4]),
        .o_is_zero  (dig_zero[k])
      );
    end
  endgenerate

  assign o_zero = zero_chain[DIGITS];
  assign o_done = (state_q == ST_DONE);
  assign o_tc   = tc_q;

  // control decode: an enabled RUN edge either decrements or is the terminal edge
  always_comb begin
    run_en   = (state_q == ST_RUN) && i_en && !i_sclr && !i_load;
    term     = run_en && o_zero;
    dec      = run_en && !o_zero;
    dig_load = i_load || (term && i_reload);
    dig_val  = i_load ? i_load_val : reload_q;
    reload_d = i_sclr ? '0 : i_load ? sat_val : reload_q;
    tc_d     = term;
    state_d  = i_sclr                ? ST_IDLE :
               i_load                ? ST_RUN  :
               (term && !i_reload)   ? ST_DONE :
                                       state_q;
  end

  // FSM state, reload register and terminal-count pulse
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end
endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: directed and randomized checks against an integer-valued reference model
module tb_bcd_down_counter;
  localparam int D  = 2;
  localparam int WW = 4 * D;

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_sclr = 1'b0, i_load = 1'b0, i_en = 1'b0, i_reload = 1'b0;
  logic [WW-1:0] i_load_val = '0;
  logic [WW-1:0] o_cnt;
  logic          o_zero, o_tc, o_done;

  int n_vec = 0, n_err = 0;
  int m_cnt = 0, m_rl = 0, m_st = 0;
  bit m_tc = 0;

  bcd_down_counter #(.DIGITS(D)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_sclr(i_sclr), .i_load(i_load),
    .i_load_val(i_load_val), .i_en(i_en), .i_reload(i_reload),
    .o_cnt(o_cnt), .o_zero(o_zero), .o_tc(o_tc), .o_done(o_done)
  );

  always #5 clk = ~clk;

  function automatic int sat_val(input logic [WW-1:0] v);
    int r = 0;
    for (int j = D - 1; j >= 0; j--) begin
      int d = int'(v[4*j +: 4]);
      r = r * 10 + ((d > 9) ? 9 : d);
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] to_bcd(input int n);
    logic [WW-1:0] r = '0;
    for (int j = 0; j < D; j++) begin
      r[4*j +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic apply(input logic sclr, input logic load, input logic [WW-1:0] val,
                       input logic en, input logic rl);
    i_sclr = sclr; i_load = load; i_load_val = val; i_en = en; i_reload = rl;
    m_tc = 0;
    if (sclr) begin m_st = 0; m_cnt = 0; m_rl = 0; end
    else if (load) begin m_st = 1; m_cnt = sat_val(val); m_rl = m_cnt; end
    else if (m_st == 1 && en) begin
      if (m_cnt != 0) m_cnt = m_cnt - 1;
      else begin
        m_tc = 1;
        if (rl) m_cnt = m_rl; else m_st = 2;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    n_vec++; if (o_cnt !== 8'h00 || o_zero !== 1'b1 || o_tc !== 1'b0 || o_done !== 1'b0) begin
      n_err++; $display("FAIL reset_init got cnt=%h z=%b tc=%b done=%b exp 00 1 0 0", o_cnt, o_zero, o_tc, o_done);
    end
    i_rst_n = 1'b1;
    apply(0, 1, 8'h37, 0, 0);
    apply(0, 0, 8'h00, 1, 0);
    n_vec++; if (o_cnt !== 8'h36) begin n_err++; $display("FAIL reset_pre got %h exp 36", o_cnt); end
    @(negedge clk); i_rst_n = 1'b0; #1;
    m_st = 0; m_cnt = 0; m_rl = 0; m_tc = 0;
    n_vec++; if (o_cnt !== 8'h00 || o_zero !== 1'b1 || o_tc !== 1'b0 || o_done !== 1'b0) begin
      n_err++; $display("FAIL reset_async got cnt=%h z=%b tc=%b done=%b exp 00 1 0 0", o_cnt, o_zero, o_tc, o_done);
    end
    @(posedge clk); #1; i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 8'h00, 1, 1);
      n_vec++; if (o_cnt !== 8'h00 || o_zero !== 1'b1 || o_tc !== 1'b0 || o_done !== 1'b0) begin
        n_err++; $display("FAIL reset_idle[%0d] got cnt=%h z=%b tc=%b done=%b exp 00 1 0 0", i, o_cnt, o_zero, o_tc, o_done);
      end
    end
  endtask

  task automatic test_borrow_chain;
    apply(0, 1, 8'h21, 0, 0);
    n_vec++; if (o_cnt !== 8'h21) begin n_err++; $display("FAIL borrow_load got %h exp 21", o_cnt); end
    for (int i = 1; i <= 21; i++) begin
      apply(0, 0, 8'h00, 1, 0);
      n_vec++; if (o_cnt !== to_bcd(21 - i)) begin
        n_err++; $display("FAIL borrow[%0d] got %h exp %h", i, o_cnt, to_bcd(21 - i));
      end
    end
  endtask

  task automatic test_stop;
    apply(0, 1, 8'h02, 0, 0);
    apply(0, 0, 8'h00, 1, 0);
    apply(0, 0, 8'h00, 1, 0);
    n_vec++; if (o_cnt !== 8'h00 || o_zero !== 1'b1 || o_tc !== 1'b0) begin
      n_err++; $display("FAIL stop_zero got cnt=%h z=%b tc=%b exp 00 1 0", o_cnt, o_zero, o_tc);
    end
    apply(0, 0, 8'h00, 1, 0);
    n_vec++; if (o_tc !== 1'b1 || o_done !== 1'b1 || o_cnt !== 8'h00) begin
      n_err++; $display("FAIL stop_tc got tc=%b done=%b cnt=%h exp 1 1 00", o_tc, o_done, o_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 8'h00, 1, 1);
      n_vec++; if (o_tc !== 1'b0 || o_done !== 1'b1 || o_cnt !== 8'h00) begin
        n_err++; $display("FAIL stop_hold[%0d] got tc=%b done=%b cnt=%h exp 0 1 00", i, o_tc, o_done, o_cnt);
      end
    end
  endtask

  task automatic test_reload;
    logic [7:0] exp_c [6] = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h03, 8'h02};
    logic       exp_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    apply(0, 1, 8'h03, 0, 1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) apply(0, 0, 8'h00, 1, 1);
      n_vec++; if (o_cnt !== exp_c[i] || o_tc !== exp_t[i] || o_done !== 1'b0) begin
        n_err++; $display("FAIL reload[%0d] got cnt=%h tc=%b done=%b exp %h %b 0", i, o_cnt, o_tc, o_done, exp_c[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_priority;
    apply(0, 1, 8'hA5, 0, 0);
    n_vec++; if (o_cnt !== 8'h95) begin n_err++; $display("FAIL sat_load got %h exp 95", o_cnt); end
    apply(0, 1, 8'h40, 1, 0);
    n_vec++; if (o_cnt !== 8'h40) begin n_err++; $display("FAIL load_over_en got %h exp 40", o_cnt); end
    apply(1, 1, 8'h77, 1, 0);
    n_vec++; if (o_cnt !== 8'h00 || o_zero !== 1'b1 || o_done !== 1'b0) begin
      n_err++; $display("FAIL sclr_over_load got cnt=%h z=%b done=%b exp 00 1 0", o_cnt, o_zero, o_done);
    end
    apply(0, 0, 8'h00, 1, 0);
    n_vec++; if (o_cnt !== 8'h00 || o_tc !== 1'b0 || o_done !== 1'b0) begin
      n_err++; $display("FAIL sclr_idle got cnt=%h tc=%b done=%b exp 00 0 0", o_cnt, o_tc, o_done);
    end
    apply(0, 1, 8'hFF, 0, 0);
    n_vec++; if (o_cnt !== 8'h99) begin n_err++; $display("FAIL sat_ff got %h exp 99", o_cnt); end
  endtask

  task automatic test_enable_gaps;
    logic       en_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] exp_c  [4] = '{8'h09, 8'h09, 8'h09, 8'h08};
    apply(0, 1, 8'h10, 0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 8'h00, en_pat[i], 0);
      n_vec++; if (o_cnt !== exp_c[i]) begin
        n_err++; $display("FAIL gap[%0d] got %h exp %h", i, o_cnt, exp_c[i]);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      logic sc = ($urandom_range(0, 39) == 0);
      logic ld = ($urandom_range(0, 11) == 0);
      logic [WW-1:0] v = ($urandom_range(0, 7) == 0) ? '0 : WW'($urandom_range(0, 255));
      apply(sc, ld, v, ($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)));
      n_vec++; if (o_cnt !== to_bcd(m_cnt) || o_zero !== (m_cnt == 0) || o_tc !== m_tc || o_done !== (m_st == 2)) begin
        n_err++; $display("FAIL rand[%0d] got cnt=%h z=%b tc=%b done=%b exp %h %b %b %b", i, o_cnt, o_zero, o_tc, o_done,
                          to_bcd(m_cnt), (m_cnt == 0), m_tc, (m_st == 2));
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_borrow_chain;
    test_stop;
    test_reload;
    test_priority;
    test_enable_gaps;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
